// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: captures control and operands,
// injects bubbles on load-use hazards and EX redirects, and counts both events.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_redirect,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              stall_if,
    output logic              flush_id,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0] ex_pc_q, ex_pc_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
    logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
    logic [4:0]        ex_rs1_q, ex_rs1_d;
    logic [4:0]        ex_rs2_q, ex_rs2_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              hz;

    // Load in EX writing a nonzero rd that the ID instruction actually reads.
    always_comb begin
        hz = ex_valid_q & ex_ctrl_q[2] & ex_ctrl_q[0] & (ex_rd_q != 5'd0) & id_valid &
             ((id_rs1_used & (id_rs1 == ex_rd_q)) | (id_rs2_used & (id_rs2 == ex_rd_q)));
    end

    assign stall_if = hz & ~ex_redirect;
    assign flush_id = ex_redirect;

    always_comb begin
        ex_valid_d = id_valid;
        ex_ctrl_d  = id_valid ? id_ctrl : '0;
        ex_pc_d    = id_pc;
        ex_imm_d   = id_imm;
        ex_rd1_d   = id_rd1;
        ex_rd2_d   = id_rd2;
        ex_rs1_d   = id_rs1;
        ex_rs2_d   = id_rs2;
        ex_rd_d    = id_rd;
        if (ex_redirect || hz) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_pc_d    = '0;
            ex_imm_d   = '0;
            ex_rd1_d   = '0;
            ex_rd2_d   = '0;
            ex_rs1_d   = '0;
            ex_rs2_d   = '0;
            ex_rd_d    = '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_pc_q     <= '0;
            ex_imm_q    <= '0;
            ex_rd1_q    <= '0;
            ex_rd2_q    <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_pc_q     <= ex_pc_d;
            ex_imm_q    <= ex_imm_d;
            ex_rd1_q    <= ex_rd1_d;
            ex_rd2_q    <= ex_rd2_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign ex_pc     = ex_pc_q;
    assign ex_imm    = ex_imm_q;
    assign ex_rd1    = ex_rd1_q;
    assign ex_rd2    = ex_rd2_q;
    assign ex_rs1    = ex_rs1_q;
    assign ex_rs2    = ex_rs2_q;
    assign ex_rd     = ex_rd_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a cycle-level pipeline model; a CNT_W=4 copy exercises saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [15:0] id_ctrl;
    logic [31:0] id_pc, id_imm, id_rd1, id_rd2;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, ex_redirect;

    logic        ex_valid, stall_if, flush_id;
    logic [15:0] ex_ctrl, stall_cnt, flush_cnt;
    logic [31:0] ex_pc, ex_imm, ex_rd1, ex_rd2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;

    logic        s_valid, s_stall_if, s_flush_id;
    logic [15:0] s_ctrl;
    logic [3:0]  s_stall_cnt, s_flush_cnt;
    logic [31:0] s_pc, s_imm, s_rd1, s_rd2;
    logic [4:0]  s_rs1, s_rs2, s_rd;

    int checks = 0;
    int errors = 0;

    // Model of the EX register contents and event counts.
    logic        m_valid;
    logic [15:0] m_ctrl;
    logic [31:0] m_pc, m_imm, m_rd1, m_rd2;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    int          m_sc, m_fc, m_sc4, m_fc4;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .cpu_clk(clk), .cpu_rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_imm(id_imm), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_redirect(ex_redirect),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .stall_if(stall_if), .flush_id(flush_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_W(4)) dut_small (
        .cpu_clk(clk), .cpu_rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_imm(id_imm), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_redirect(ex_redirect),
        .ex_valid(s_valid), .ex_ctrl(s_ctrl), .ex_pc(s_pc), .ex_imm(s_imm),
        .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
        .stall_if(s_stall_if), .flush_id(s_flush_id), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    function automatic bit model_hz();
        return m_valid && m_ctrl[2] && m_ctrl[0] && (m_rd != 0) && id_valid &&
               ((id_rs1_used && id_rs1 == m_rd) || (id_rs2_used && id_rs2 == m_rd));
    endfunction

    // Advance model and DUT by one edge; leaves time at posedge + 1.
    task automatic tick();
        bit hz;
        hz = model_hz();
        if (!rst_n) begin
            {m_valid, m_ctrl, m_pc, m_imm, m_rd1, m_rd2, m_rs1, m_rs2, m_rd} = '0;
            m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
        end else begin
            if (ex_redirect) begin
                if (m_fc < 65535) m_fc++;
                if (m_fc4 < 15) m_fc4++;
            end else if (hz) begin
                if (m_sc < 65535) m_sc++;
                if (m_sc4 < 15) m_sc4++;
            end
            if (ex_redirect || hz) begin
                {m_valid, m_ctrl, m_pc, m_imm, m_rd1, m_rd2, m_rs1, m_rs2, m_rd} = '0;
            end else begin
                m_valid = id_valid;
                m_ctrl  = id_valid ? id_ctrl : 16'h0;
                m_pc = id_pc; m_imm = id_imm; m_rd1 = id_rd1; m_rd2 = id_rd2;
                m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [15:0] c, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2);
        id_valid = v; id_ctrl = c; id_pc = pc;
        id_imm = pc ^ 32'h1234_0000; id_rd1 = pc + 32'h100; id_rd2 = pc + 32'h200;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_used = u1; id_rs2_used = u2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ex_redirect = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_redirect = 1'b1;
        set_id(1'b1, 16'hFFFF, 32'hDEAD_BEEF, 5'd7, 5'd9, 5'd11, 1'b1, 1'b1);
        tick();
        tick();
        checks++;
        if ({ex_valid, ex_ctrl, ex_pc, ex_imm, ex_rd1, ex_rd2, ex_rs1, ex_rs2, ex_rd,
             stall_cnt, flush_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got valid=%0b ctrl=%h pc=%h rd=%0d scnt=%0d fcnt=%0d, need all 0",
                     ex_valid, ex_ctrl, ex_pc, ex_rd, stall_cnt, flush_cnt);
        end
        rst_n = 1'b1; ex_redirect = 1'b0;
        set_id(1'b1, 16'h0000, 32'h0000_0004, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick();
        checks++;
        if (ex_pc !== 32'h4 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_load: got pc=%h valid=%0b, need pc=00000004 valid=1", ex_pc, ex_valid);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 16'h0005, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);  // lw x5
        tick();
        set_id(1'b1, 16'h0001, 32'h104, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1);  // add x6,x5,x3
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            errors++; $display("FAIL lu_stall: got stall_if=%0b, need 1", stall_if);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 16'h0 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_bubble: got valid=%0b ctrl=%h scnt=%0d, need 0 0000 1", ex_valid, ex_ctrl, stall_cnt);
        end
        checks++;
        if (stall_if !== 1'b0) begin
            errors++; $display("FAIL lu_release: got stall_if=%0b, need 0", stall_if);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rs1 !== 5'd5 || ex_pc !== 32'h104 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_advance: got valid=%0b rd=%0d rs1=%0d pc=%h scnt=%0d, need 1 6 5 00000104 1",
                     ex_valid, ex_rd, ex_rs1, ex_pc, stall_cnt);
        end
        // store consuming the load result through rs2
        set_id(1'b1, 16'h0005, 32'h108, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 16'h0002, 32'h10C, 5'd2, 5'd8, 5'd0, 1'b1, 1'b1);
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            errors++; $display("FAIL store_rs2_stall: got stall_if=%0b, need 1", stall_if);
        end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1'b1, 16'h0005, 32'h200, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);  // lw x0
        tick();
        set_id(1'b1, 16'h0001, 32'h204, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        #1;
        checks++;
        if (stall_if !== 1'b0) begin
            errors++; $display("FAIL x0_stall: got stall_if=%0b, need 0", stall_if);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL x0_advance: got valid=%0b pc=%h scnt=%0d, need 1 00000204 0", ex_valid, ex_pc, stall_cnt);
        end
    endtask

    task automatic test_redirect_hazard();
        do_reset();
        set_id(1'b1, 16'h0005, 32'h300, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 16'h0001, 32'h304, 5'd7, 5'd2, 5'd9, 1'b1, 1'b1);
        ex_redirect = 1'b1;
        #1;
        checks++;
        if (stall_if !== 1'b0 || flush_id !== 1'b1) begin
            errors++;
            $display("FAIL rh_comb: got stall_if=%0b flush_id=%0b, need 0 1", stall_if, flush_id);
        end
        tick();
        ex_redirect = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rh_bubble: got valid=%0b fcnt=%0d scnt=%0d, need 0 1 0", ex_valid, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_id(1'b1, 16'h0001, 32'h400, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        ex_redirect = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14 || i == 15) begin
                checks++;
                if (s_flush_cnt !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_edge_%0d: got flush_cnt=%0d, need 15", i + 1, s_flush_cnt);
                end
            end
        end
        ex_redirect = 1'b0;
        checks++;
        if (s_flush_cnt !== 4'd15 || flush_cnt !== 16'd20) begin
            errors++;
            $display("FAIL sat_hold: got small=%0d wide=%0d, need 15 20", s_flush_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1'b1, 16'h0005, 32'h500, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 16'h0001, 32'h504, 5'd3, 5'd12, 5'd13, 1'b0, 1'b1);
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            errors++; $display("FAIL rms_pre: got stall_if=%0b, need 1", stall_if);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ex_valid, ex_ctrl, ex_pc, ex_imm, ex_rd1, ex_rd2, ex_rs1, ex_rs2, ex_rd,
             stall_cnt, flush_cnt} !== '0) begin
            errors++;
            $display("FAIL rms_regs: got valid=%0b ctrl=%h pc=%h rd=%0d scnt=%0d, need all 0",
                     ex_valid, ex_ctrl, ex_pc, ex_rd, stall_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (stall_if !== 1'b0) begin
            errors++; $display("FAIL rms_post: got stall_if=%0b, need 0", stall_if);
        end
    endtask

    // Random traffic; upstream honours stall_if by holding the ID inputs.
    task automatic test_random();
        bit held;
        do_reset();
        held = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            if (!held) begin
                set_id(1'($urandom_range(0, 9) != 0), 16'($urandom), $urandom,
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom));
            end
            ex_redirect = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
            #1;
            checks++;
            if (stall_if !== (rst_n ? (model_hz() && !ex_redirect) : stall_if) || flush_id !== ex_redirect) begin
                errors++;
                $display("FAIL rand_comb[%0d]: got stall_if=%0b flush_id=%0b, need %0b %0b", n,
                         stall_if, flush_id, model_hz() && !ex_redirect, ex_redirect);
            end
            held = rst_n && model_hz() && !ex_redirect;
            tick();
            checks++;
            if ({ex_valid, ex_ctrl, ex_pc, ex_imm, ex_rd1, ex_rd2, ex_rs1, ex_rs2, ex_rd,
                 stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt} !==
                {m_valid, m_ctrl, m_pc, m_imm, m_rd1, m_rd2, m_rs1, m_rs2, m_rd,
                 16'(m_sc), 16'(m_fc), 4'(m_sc4), 4'(m_fc4)}) begin
                errors++;
                $display("FAIL rand_regs[%0d]: got v=%0b c=%h pc=%h rd=%0d sc=%0d fc=%0d, need v=%0b c=%h pc=%h rd=%0d sc=%0d fc=%0d",
                         n, ex_valid, ex_ctrl, ex_pc, ex_rd, stall_cnt, flush_cnt,
                         m_valid, m_ctrl, m_pc, m_rd, m_sc, m_fc);
            end
        end
        rst_n = 1'b1;
        ex_redirect = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ex_redirect = 1'b0;
        set_id(1'b0, 16'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        {m_valid, m_ctrl, m_pc, m_imm, m_rd1, m_rd2, m_rs1, m_rs2, m_rd} = '0;
        m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
        #2;
        test_reset();
        test_load_use();
        test_x0();
        test_redirect_hazard();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the five-stage RV32I core.
- Captures the decoder's control bundle and the ID-stage operands into EX-stage registers.
- Detects load-use hazards: stalls PC and IF/ID, and injects a bubble into EX.
- Squashes the ID instruction when EX redirects the PC (taken branch, jal, jalr).
- Keeps saturating stall and flush counters for the trace-test harness.

Parameters:
- DATA_W, 32, width of pc, imm and register operands.
- CTRL_W, 16, width of the packed control bundle.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- cpu_clk  in  1  core clock; all state updates on the rising edge.
- cpu_rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  CTRL_W  packed control: [0]we_reg [1]we_dram [2]load [4:3]wb_type [8:5]alu_sel [10:9]comp_sel [11]unsigned [12]rd1_pc_sel [13]rd2_imm_sel [15:14]dram_ext.
- id_pc, id_imm, id_rd1, id_rd2  in  DATA_W each  ID-stage pc, immediate and register-file read data.
- id_rs1, id_rs2, id_rd  in  5 each  ID register addresses.
- id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_pc, ex_imm, ex_rd1, ex_rd2  out  DATA_W each  registered data.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered addresses.
- stall_if  out  1  combinational; freeze PC and IF/ID this cycle.
- flush_id  out  1  combinational; IF/ID loads a bubble next edge (equals ex_redirect).
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (cpu_rst_n=0 at an edge): every registered output goes to 0, including ex_valid, ex_ctrl, data, addresses and both counters. Reset mid-stall discards the pending instruction.
- The control fields of the bundle are all zero at reset, so nothing writes the register file or DRAM.
- Hazard condition: hz = ex_valid & ex_ctrl[2] & ex_ctrl[0] & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)) & id_valid.
- stall_if = hz & ~ex_redirect. The redirect squashes the dependent ID instruction, so no stall is needed.
- Next-state priority at each edge:
  1. Reset.
  2. Flush: ex_redirect=1 → EX loads a bubble.
  3. Hazard: hz=1 → EX loads a bubble; ID contents are held by upstream via stall_if.
  4. Normal: load all id_* fields; ex_valid <= id_valid.
- Bubble: ex_valid=0, ex_ctrl=0, data and addresses=0 (deterministic for trace compare).
- id_valid=0 in the normal case loads ex_valid=0 and ex_ctrl=0.
- Latency: one cycle from ID inputs to ex_* outputs.
- Each load-use hazard costs exactly one bubble. On the next cycle EX no longer holds the load, so hz deasserts and the held ID instruction advances.
- stall_cnt increments on each edge where stall_if=1.
- flush_cnt increments on each edge where ex_redirect=1.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- ex_rd=0 never produces a hazard. A load to x0 followed by a use of x0 must not stall.
- Hazard and redirect in the same cycle: one bubble, flush_cnt+1, stall_cnt unchanged.
- A store after a load that uses the load result via rs2 (id_rs2_used=1) stalls like any other consumer.

Test Plan:
1. Reset held 2 cycles with all id_* inputs nonzero → every output 0 and counters 0. After release, id_pc=0x0000_0004, id_valid=1 → ex_pc=0x0000_0004, ex_valid=1 one cycle later.
2. lw x5 in EX (ex_ctrl[2]=1, ex_ctrl[0]=1, ex_rd=5), ID add with rs1=5, rs1_used=1 → stall_if=1. Next cycle: ex_valid=0, ex_ctrl=0, stall_cnt=1. Following cycle: the add reaches EX.
3. Same as 2 but ex_rd=0, id_rs1=0 → stall_if=0, no bubble, stall_cnt unchanged.
4. ex_redirect=1 with hz=1 simultaneously → stall_if=0, flush_id=1. Next cycle: ex_valid=0, flush_cnt=1, stall_cnt=0.
5. CNT_W=4, 20 consecutive redirects → flush_cnt holds at 15.
6. Assert reset during a stall cycle → all outputs 0 the next cycle; stall_if=0 afterwards.
